// File: rtl/nucleic_acid_sequencer.sv
// nucleic_acid_sequencer
// Runs one extraction protocol per accepted start:
//   FILL -> SETTLE -> MIX -> SETTLE -> TRAP -> SETTLE -> WASH -> SETTLE -> ELUTE -> DONE
// SETTLE is a one-cycle all-closed gap between steps.
// Every output is decoded from registered state, so no input reaches an output combinationally.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start, abort       protocol control
//   *_len, mix_strokes step lengths, latched when start is accepted (0 acts as 1)
//   busy, done, aborted, step   status outputs
//   *_ctl              valve controls (1 = open)
//   pump1..3           peristaltic pump phases
module nucleic_acid_sequencer #(
  parameter int PUMP_DIV = 4,
  parameter int CNT_W    = 16,
  parameter int STK_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] fill_len,
  input  logic [STK_W-1:0] mix_strokes,
  input  logic [CNT_W-1:0] trap_len,
  input  logic [CNT_W-1:0] wash_len,
  input  logic [CNT_W-1:0] elute_len,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [2:0]       step,
  output logic             lysis_ctl,
  output logic             wash_ctl,
  output logic             elute_ctl,
  output logic             vertical_ctl,
  output logic             horiz_ctl,
  output logic             loop_exit_ctl,
  output logic             bead_vtl_ctl,
  output logic             bead_trap_ctl,
  output logic             collection_ctl,
  output logic             waste_ctl,
  output logic             pump1,
  output logic             pump2,
  output logic             pump3
);
  localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_MIX = 3'd2, S_TRAP = 3'd3,
    S_WASH = 3'd4, S_ELUTE = 3'd5, S_SETTLE = 3'd6, S_DONE = 3'd7
  } state_e;

  state_e           state_q, state_d, ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       ph_q, ph_d;
  logic [STK_W-1:0] stk_q, stk_d;
  logic [CNT_W-1:0] fill_q, trap_q, wash_q, elute_q;
  logic [STK_W-1:0] strokes_q;
  logic             aborted_q, aborted_d;
  logic             accept, busy_st, div_wrap, mix_last;

  assign busy_st  = (state_q != S_IDLE) && (state_q != S_DONE);
  // Start is refused in a cycle where abort is also high.
  assign accept   = (state_q == S_IDLE) && start && !abort;
  assign div_wrap = (div_q == DIV_W'(PUMP_DIV - 1));
  assign mix_last = div_wrap && (ph_q == 3'd5) && (stk_q == strokes_q - STK_W'(1));

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    aborted_d = 1'b0;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_FILL;
      S_FILL:   if (cnt_q == fill_q - CNT_W'(1))  begin state_d = S_SETTLE; ret_d = S_MIX;   end
      S_MIX:    if (mix_last)                     begin state_d = S_SETTLE; ret_d = S_TRAP;  end
      S_TRAP:   if (cnt_q == trap_q - CNT_W'(1))  begin state_d = S_SETTLE; ret_d = S_WASH;  end
      S_WASH:   if (cnt_q == wash_q - CNT_W'(1))  begin state_d = S_SETTLE; ret_d = S_ELUTE; end
      S_ELUTE:  if (cnt_q == elute_q - CNT_W'(1)) state_d = S_DONE;
      S_SETTLE: state_d = ret_q;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (busy_st && abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end
  end

  // Counters clear on every state change, so the pump pattern restarts at
  // phase 0 on entry to MIX and TRAP.
  always_comb begin
    cnt_d = '0;
    div_d = '0;
    ph_d  = '0;
    stk_d = '0;
    if (state_d == state_q && busy_st) begin
      cnt_d = cnt_q + CNT_W'(1);
      div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      ph_d  = ph_q;
      stk_d = stk_q;
      if (div_wrap) begin
        ph_d = (ph_q == 3'd5) ? 3'd0 : ph_q + 3'd1;
        if (ph_q == 3'd5) stk_d = stk_q + STK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      ph_q      <= '0;
      stk_q     <= '0;
      fill_q    <= CNT_W'(1);
      trap_q    <= CNT_W'(1);
      wash_q    <= CNT_W'(1);
      elute_q   <= CNT_W'(1);
      strokes_q <= STK_W'(1);
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      ph_q      <= ph_d;
      stk_q     <= stk_d;
      aborted_q <= aborted_d;
      if (accept) begin
        fill_q    <= (fill_len    == '0) ? CNT_W'(1) : fill_len;
        trap_q    <= (trap_len    == '0) ? CNT_W'(1) : trap_len;
        wash_q    <= (wash_len    == '0) ? CNT_W'(1) : wash_len;
        elute_q   <= (elute_len   == '0) ? CNT_W'(1) : elute_len;
        strokes_q <= (mix_strokes == '0) ? STK_W'(1) : mix_strokes;
      end
    end
  end

  // Moore output decode
  logic [9:0] ctl;
  logic [2:0] pmp;
  always_comb begin
    ctl = '0;
    pmp = '0;
    // order: lysis wash elute vertical horiz loop_exit bead_vtl bead_trap collection waste
    unique case (state_q)
      S_FILL:  ctl = 10'b1001000000;
      S_MIX:   ctl = 10'b0000100000;
      S_TRAP:  ctl = 10'b0000011101;
      S_WASH:  ctl = 10'b0101010101;
      S_ELUTE: ctl = 10'b0011010110;
      default: ctl = '0;
    endcase
    if (state_q == S_MIX || state_q == S_TRAP) begin
      unique case (ph_q)
        3'd0:    pmp = 3'b100;
        3'd1:    pmp = 3'b110;
        3'd2:    pmp = 3'b010;
        3'd3:    pmp = 3'b011;
        3'd4:    pmp = 3'b001;
        3'd5:    pmp = 3'b101;
        default: pmp = 3'b000;
      endcase
    end
  end

  assign {lysis_ctl, wash_ctl, elute_ctl, vertical_ctl, horiz_ctl, loop_exit_ctl,
          bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl} = ctl;
  assign {pump1, pump2, pump3} = pmp;
  assign busy    = busy_st;
  assign done    = (state_q == S_DONE);
  assign aborted = aborted_q;
  assign step    = state_q;
endmodule

// File: tb/tb_nucleic_acid_sequencer.sv
// Scoreboard bench: each scenario pushes its expected per-cycle output
// frames when stimulus is driven; the monitor pops one per cycle.
module tb_nucleic_acid_sequencer;
  localparam int PD = 2;

  typedef struct packed {
    logic [2:0] step;
    logic       busy, done, aborted;
    logic [9:0] ctl;
    logic [2:0] pump;
  } frame_t;

  localparam logic [2:0] PT [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  logic gclk = 1'b0;
  logic rst_n, start, abort;
  logic [15:0] fill_len, trap_len, wash_len, elute_len;
  logic [7:0]  mix_strokes;
  logic busy, done, aborted;
  logic [2:0] step;
  logic lysis_ctl, wash_ctl, elute_ctl, vertical_ctl, horiz_ctl, loop_exit_ctl;
  logic bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl, pump1, pump2, pump3;

  always #5 gclk = ~gclk;

  nucleic_acid_sequencer #(.PUMP_DIV(PD), .CNT_W(16), .STK_W(8)) dut (
    .clk(gclk), .rst_n(rst_n), .start(start), .abort(abort),
    .fill_len(fill_len), .mix_strokes(mix_strokes), .trap_len(trap_len),
    .wash_len(wash_len), .elute_len(elute_len),
    .busy(busy), .done(done), .aborted(aborted), .step(step),
    .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
    .vertical_ctl(vertical_ctl), .horiz_ctl(horiz_ctl), .loop_exit_ctl(loop_exit_ctl),
    .bead_vtl_ctl(bead_vtl_ctl), .bead_trap_ctl(bead_trap_ctl),
    .collection_ctl(collection_ctl), .waste_ctl(waste_ctl),
    .pump1(pump1), .pump2(pump2), .pump3(pump3)
  );

  int total = 0, bad = 0;
  frame_t sb[$];
  frame_t tr[$];
  bit mon_en = 0;
  logic [2:0] prev_pump = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic frame_t fr(input int st, input int ph, input bit ab);
    frame_t f;
    f.step    = 3'(st);
    f.busy    = (st >= 1 && st <= 6);
    f.done    = (st == 7);
    f.aborted = ab;
    case (st)
      1: f.ctl = 10'b1001000000;
      2: f.ctl = 10'b0000100000;
      3: f.ctl = 10'b0000011101;
      4: f.ctl = 10'b0101010101;
      5: f.ctl = 10'b0011010110;
      default: f.ctl = '0;
    endcase
    f.pump = (ph >= 0) ? PT[ph] : 3'b000;
    return f;
  endfunction

  // Expected frames from the first FILL cycle through DONE.
  task automatic gen(input int f, input int s, input int t, input int w, input int e);
    tr.delete();
    if (f == 0) f = 1;
    if (s == 0) s = 1;
    if (t == 0) t = 1;
    if (w == 0) w = 1;
    if (e == 0) e = 1;
    for (int i = 0; i < f; i++) tr.push_back(fr(1, -1, 0));
    tr.push_back(fr(6, -1, 0));
    for (int i = 0; i < s * 6 * PD; i++) tr.push_back(fr(2, (i / PD) % 6, 0));
    tr.push_back(fr(6, -1, 0));
    for (int i = 0; i < t; i++) tr.push_back(fr(3, (i / PD) % 6, 0));
    tr.push_back(fr(6, -1, 0));
    for (int i = 0; i < w; i++) tr.push_back(fr(4, -1, 0));
    tr.push_back(fr(6, -1, 0));
    for (int i = 0; i < e; i++) tr.push_back(fr(5, -1, 0));
    tr.push_back(fr(7, -1, 0));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge gclk);
    chk("drain", 32'(sb.size()), 0);
  endtask

  // cut: cycle (1 = first FILL) in which kind 1 (abort) or kind 2 (reset) is applied.
  task automatic run(input int f, input int s, input int t, input int w, input int e,
                     input int cut, input int kind, input int mod_at, input int start_at);
    int n;
    gen(f, s, t, w, e);
    @(posedge gclk); #1;
    fill_len = 16'(f); mix_strokes = 8'(s); trap_len = 16'(t);
    wash_len = 16'(w); elute_len = 16'(e);
    start = 1'b1;
    sb.push_back(fr(0, -1, 0));
    @(posedge gclk); #1;
    start = 1'b0;
    if (cut == 0) begin
      foreach (tr[i]) sb.push_back(tr[i]);
      sb.push_back(fr(0, -1, 0));
      n = tr.size() + 1;
    end else begin
      for (int i = 0; i < cut; i++) sb.push_back(tr[i]);
      sb.push_back(fr(0, -1, kind == 1));
      sb.push_back(fr(0, -1, 0));
      n = cut + 2;
    end
    for (int c = 1; c <= n; c++) begin
      start = (c == start_at);
      if (c == mod_at) fill_len = 16'd9;
      if (c == cut && kind == 1) abort = 1'b1;
      if (c == cut && kind == 2) rst_n = 1'b0;
      if (c == cut + 1) begin abort = 1'b0; rst_n = 1'b1; end
      @(posedge gclk); #1;
    end
    start = 1'b0;
    drain();
  endtask

  always @(negedge gclk) begin
    frame_t cur, e;
    cur = {step, busy, done, aborted,
           lysis_ctl, wash_ctl, elute_ctl, vertical_ctl, horiz_ctl, loop_exit_ctl,
           bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl,
           pump1, pump2, pump3};
    if (mon_en) begin
      chk("inv_reagent", 32'($countones({lysis_ctl, wash_ctl, elute_ctl}) <= 1), 1);
      chk("inv_outlet", 32'(collection_ctl & waste_ctl), 0);
      if (prev_pump != 3'b000 && cur.pump != 3'b000 && prev_pump != cur.pump)
        chk("inv_pump_step", 32'($countones(prev_pump ^ cur.pump)), 1);
      prev_pump = cur.pump;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame", 32'(cur), 32'(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    fill_len = '0; mix_strokes = '0; trap_len = '0; wash_len = '0; elute_len = '0;
    repeat (3) @(posedge gclk);
    #1;
    mon_en = 1;
    sb.push_back(fr(0, -1, 0));
    rst_n = 1'b1;
    sb.push_back(fr(0, -1, 0));
    drain();

    // nominal run
    run(4, 1, 3, 5, 2, 0, 0, 0, 0);
    // zero lengths act as one
    run(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // two strokes, trap ends mid-stroke
    run(1, 2, 7, 1, 3, 0, 0, 0, 0);
    // abort in WASH cycle 2 (WASH spans cycles 23..27)
    run(4, 1, 3, 5, 2, 24, 1, 0, 0);
    // full protocol after abort
    run(4, 1, 3, 5, 2, 0, 0, 0, 0);
    // fill_len changed mid-FILL, start pulsed during MIX
    run(4, 1, 3, 5, 2, 0, 0, 2, 8);
    // reset during TRAP (cycles 19..21)
    run(4, 1, 3, 5, 2, 20, 2, 0, 0);

    // abort together with start in IDLE: start refused, no pulse
    @(posedge gclk); #1;
    start = 1'b1; abort = 1'b1;
    sb.push_back(fr(0, -1, 0));
    @(posedge gclk); #1;
    start = 1'b0; abort = 1'b0;
    sb.push_back(fr(0, -1, 0));
    sb.push_back(fr(0, -1, 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nucleic_acid_sequencer.md
Name: nucleic_acid_sequencer

Overview:
- Synchronous protocol controller that drives the valve-control and peristaltic-pump lines of the nucleic-acid reactor array.
- Sits directly upstream of the reactor array. Its outputs connect one-to-one to the shared control nets common to all reactor instances.
- Runs one extraction protocol per start: fill/lyse, mix, bead trap, wash, elute.
- Enforces break-before-make between steps and mutual exclusion of reagent and outlet valves.

Parameters:
- PUMP_DIV, 4, clocks per pump phase (≥1).
- CNT_W, 16, width of the cycle-length inputs.
- STK_W, 8, width of the mix-stroke input.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin protocol; sampled only in IDLE
- abort  in  1  terminate protocol immediately
- fill_len  in  CNT_W  FILL duration in cycles
- mix_strokes  in  STK_W  MIX duration in full pump strokes
- trap_len  in  CNT_W  TRAP duration in cycles
- wash_len  in  CNT_W  WASH duration in cycles
- elute_len  in  CNT_W  ELUTE duration in cycles
- busy  out  1  protocol in progress
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort pulse
- step  out  3  current state code
- lysis_ctl, wash_ctl, elute_ctl, vertical_ctl, horiz_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl  out  1 each  valve controls (1 = valve open)
- pump1, pump2, pump3  out  1 each  pump valve phases

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: state IDLE; all ctl and pump outputs 0; busy=0, done=0, aborted=0, step=0.
- Outputs: all outputs are Moore decodes of registered state and counters. No combinational path from any input to any output.
- Length latching:
  - fill_len, mix_strokes, trap_len, wash_len and elute_len are latched on the edge that accepts start.
  - Changes to these inputs during a run are ignored.
  - A latched value of 0 is treated as 1.
- Step codes: IDLE=0, FILL=1, MIX=2, TRAP=3, WASH=4, ELUTE=5, SETTLE=6, DONE=7.
- Sequence:
  - IDLE → FILL on start.
  - FILL → SETTLE → MIX → SETTLE → TRAP → SETTLE → WASH → SETTLE → ELUTE → DONE → IDLE.
- Step durations:
  - SETTLE: exactly 1 cycle, all ctl/pump outputs 0 (break-before-make).
  - DONE: exactly 1 cycle.
  - FILL, TRAP, WASH, ELUTE: exactly their latched length in cycles.
  - MIX: exactly mix_strokes × 6 × PUMP_DIV cycles.
- First FILL cycle is the cycle immediately after the edge that sampled start.
- Valve decode (ctl outputs not listed are 0):
  - FILL: lysis_ctl, vertical_ctl.
  - MIX: horiz_ctl, plus pump pattern.
  - TRAP: bead_vtl_ctl, loop_exit_ctl, bead_trap_ctl, waste_ctl, plus pump pattern.
  - WASH: wash_ctl, vertical_ctl, loop_exit_ctl, bead_trap_ctl, waste_ctl.
  - ELUTE: elute_ctl, vertical_ctl, loop_exit_ctl, bead_trap_ctl, collection_ctl.
- Pump pattern:
  - {pump1,pump2,pump3} cycles through 100, 110, 010, 011, 001, 101; each phase is held PUMP_DIV cycles.
  - The pattern restarts at 100 on entry to MIX and on entry to TRAP.
  - TRAP may end mid-stroke.
  - Pumps are 000 in every other state.
- Invariants, checked every cycle:
  - At most one of lysis_ctl, wash_ctl, elute_ctl is 1.
  - collection_ctl and waste_ctl are never both 1.
  - Exactly one pump phase changes per phase transition.
- busy: 1 in FILL, MIX, TRAP, WASH, ELUTE and SETTLE; 0 in IDLE and DONE.
- done: 1 only in DONE.
- start handling:
  - start in a non-IDLE state is ignored; it is not queued.
  - start held high is re-accepted in the first IDLE cycle after DONE.
- abort:
  - In any busy state, abort sampled high sends the next state to IDLE with all ctl outputs 0 and aborted=1 for that one cycle; no done pulse.
  - abort in IDLE or DONE is ignored.
  - When abort and start are both high in IDLE, the cycle behaves as abort-only: start is not accepted in that cycle.
- rst_n low mid-protocol: all outputs return to reset values in the next cycle; no done or aborted pulse.
- Counters: all counters saturate-free. Widths are sized so that max length × 6 × PUMP_DIV does not overflow; the stroke cycle count uses a separate phase counter and a stroke counter, not a product.

Test Plan:
- Nominal run, PUMP_DIV=2, fill=4, strokes=1, trap=3, wash=5, elute=2, start pulse → busy=1 for 30 cycles. Durations: FILL 4, SETTLE 1, MIX 12, SETTLE 1, TRAP 3, SETTLE 1, WASH 5, SETTLE 1, ELUTE 2. Then done=1 for exactly one cycle at cycle 31, then IDLE.
- Pump check in MIX, PUMP_DIV=2 → pumps show 100,100,110,110,010,010,011,011,001,001,101,101, then 000 in the following SETTLE. TRAP restarts at 100.
- Zero lengths, all length inputs = 0 → each step lasts 1 cycle and MIX lasts 6×PUMP_DIV cycles; the run completes with done.
- abort during WASH cycle 2 → next cycle all ctl=0, aborted=1, step=0, no done pulse. A subsequent start runs the full protocol.
- Change fill_len from 4 to 9 mid-FILL, and pulse start during MIX → FILL still lasts 4 cycles and the MIX start is ignored.
- rst_n=0 for 1 cycle during TRAP → next cycle all outputs 0, step=0, no pulses. The invariant assertions hold for the whole test.
